// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: geometry, entry layout and pop encodings.
package inst_fetch_queue_pkg;

  localparam int unsigned IFQ_DEPTH   = 16;
  localparam int unsigned IFQ_INST_W  = 32;
  localparam int unsigned IFQ_ADDR_W  = 32;
  localparam int unsigned IFQ_PTR_W   = $clog2(IFQ_DEPTH);
  localparam int unsigned IFQ_CNT_W   = IFQ_PTR_W + 1;
  localparam int unsigned IFQ_ENTRY_W = IFQ_INST_W + IFQ_ADDR_W;

  // One queued fetch: instruction word with its PC
  typedef struct packed {
    logic [IFQ_INST_W-1:0] inst;
    logic [IFQ_ADDR_W-1:0] addr;
  } ifq_entry_t;

  // Decode pop request encodings; the top encoding behaves like a pop of two
  typedef enum logic [1:0] {
    POP_NONE    = 2'd0,
    POP_ONE     = 2'd1,
    POP_TWO     = 2'd2,
    POP_TWO_ALT = 2'd3
  } pop_enc_e;

endpackage

// File: rtl/inst_fetch_queue_ram.sv
// Entry storage for the fetch queue: two write ports and two asynchronous read ports.
module inst_fetch_queue_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     we1,
  input  logic [$clog2(DEPTH)-1:0] waddr1,
  input  logic [WIDTH-1:0]         wdata1,
  input  logic                     we2,
  input  logic [$clog2(DEPTH)-1:0] waddr2,
  input  logic [WIDTH-1:0]         wdata2,
  input  logic [$clog2(DEPTH)-1:0] raddr1,
  output logic [WIDTH-1:0]         rdata1,
  input  logic [$clog2(DEPTH)-1:0] raddr2,
  output logic [WIDTH-1:0]         rdata2
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write ports always target distinct addresses (addr, addr+1)
  always_ff @(posedge clk) begin
    if (we1) mem[waddr1] <= wdata1;
    if (we2) mem[waddr2] <= wdata2;
  end

  // Asynchronous reads of the two oldest entries
  always_comb begin
    rdata1 = mem[raddr1];
    rdata2 = mem[raddr2];
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between the ICache path and dual-issue decode.
// Accepts 0/1/2 entries per cycle, presents the two oldest, decode pops 0/1/2.
// Optional feature macro: IFQ_BYPASS_EN (empty-queue zero-latency bypass).
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = IFQ_DEPTH,
  parameter int unsigned INST_W = IFQ_INST_W,
  parameter int unsigned ADDR_W = IFQ_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       inst1_valid_i,
  input  logic                       inst2_valid_i,
  input  logic [INST_W-1:0]          inst1_i,
  input  logic [INST_W-1:0]          inst2_i,
  input  logic [ADDR_W-1:0]          inst1_addr_i,
  input  logic [ADDR_W-1:0]          inst2_addr_i,
  input  logic [1:0]                 pop_num_i,
  output logic [INST_W-1:0]          head1_o,
  output logic [ADDR_W-1:0]          head1_addr_o,
  output logic                       head1_valid_o,
  output logic [INST_W-1:0]          head2_o,
  output logic [ADDR_W-1:0]          head2_addr_o,
  output logic                       head2_valid_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = INST_W + ADDR_W;

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic [1:0]         push_req;
  logic [1:0]         push_acc;
  logic [1:0]         pop_req;
  logic [1:0]         pop_eff;
  logic [CNT_W-1:0]   pop_avail;
  logic [1:0]         skip;
  logic [1:0]         store_n;

  logic               we1;
  logic               we2;
  logic [ENTRY_W-1:0] wdata1;
  logic [ENTRY_W-1:0] wdata2;
  logic [ENTRY_W-1:0] rdata1;
  logic [ENTRY_W-1:0] rdata2;

  // Occupancy-derived status
  always_comb begin
    full_o  = count > CNT_W'(DEPTH - 2);
    count_o = count;
  end

  // Push/pop accounting, including the empty-queue bypass when enabled
  always_comb begin
    push_req = {1'b0, inst1_valid_i} + {1'b0, inst1_valid_i & inst2_valid_i};
    push_acc = full_o ? 2'd0 : push_req;

    pop_req = 2'd0;
    unique case (pop_enc_e'(pop_num_i))
      POP_NONE:    pop_req = 2'd0;
      POP_ONE:     pop_req = 2'd1;
      POP_TWO:     pop_req = 2'd2;
      POP_TWO_ALT: pop_req = 2'd2;
      default:     pop_req = 2'd2;
    endcase

    pop_avail = count;
`ifdef IFQ_BYPASS_EN
    if (count == '0 && !flush) pop_avail = CNT_W'(push_acc);
`endif
    pop_eff = (CNT_W'(pop_req) > pop_avail) ? pop_avail[1:0] : pop_req;

    skip = 2'd0;
`ifdef IFQ_BYPASS_EN
    if (count == '0 && !flush) skip = pop_eff;
`endif
    store_n = push_acc - skip;
  end

  // Write-port steering: bypass-consumed slots are never stored
  always_comb begin
    wdata1 = {inst1_i, inst1_addr_i};
    wdata2 = {inst2_i, inst2_addr_i};
    if (skip == 2'd1) wdata1 = {inst2_i, inst2_addr_i};
    we1 = !rst && !flush && (store_n != 2'd0);
    we2 = !rst && !flush && (store_n == 2'd2);
  end

  // Pointer and occupancy state; flush discards everything including same-cycle traffic
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(store_n);
      rd_ptr <= rd_ptr + PTR_W'(pop_eff - skip);
      count  <= count + CNT_W'(push_acc) - CNT_W'(pop_eff);
    end
  end

  inst_fetch_queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk    (clk),
    .we1    (we1),
    .waddr1 (wr_ptr),
    .wdata1 (wdata1),
    .we2    (we2),
    .waddr2 (wr_ptr + PTR_W'(1)),
    .wdata2 (wdata2),
    .raddr1 (rd_ptr),
    .rdata1 (rdata1),
    .raddr2 (rd_ptr + PTR_W'(1)),
    .rdata2 (rdata2)
  );

  // Head presentation, optionally bypassing the incoming pair on an empty queue
  always_comb begin
    {head1_o, head1_addr_o} = rdata1;
    {head2_o, head2_addr_o} = rdata2;
    head1_valid_o = count >= CNT_W'(1);
    head2_valid_o = count >= CNT_W'(2);
`ifdef IFQ_BYPASS_EN
    if (count == '0 && !flush) begin
      head1_o       = inst1_i;
      head1_addr_o  = inst1_addr_i;
      head2_o       = inst2_i;
      head2_addr_o  = inst2_addr_i;
      head1_valid_o = inst1_valid_i;
      head2_valid_o = inst1_valid_i & inst2_valid_i;
    end
`endif
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue against a queue-based reference model.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        inst1_valid_i, inst2_valid_i;
  logic [31:0] inst1_i, inst2_i, inst1_addr_i, inst2_addr_i;
  logic [1:0]  pop_num_i;
  logic [31:0] head1_o, head1_addr_o, head2_o, head2_addr_o;
  logic        head1_valid_o, head2_valid_o, full_o;
  logic [4:0]  count_o;

  int n_checks = 0;
  int n_errors = 0;

  ifq_entry_t  mq[$];
  logic [31:0] dut_pops[$];

  always #5 clk = ~clk;

  inst_fetch_queue dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .inst1_valid_i (inst1_valid_i),
    .inst2_valid_i (inst2_valid_i),
    .inst1_i       (inst1_i),
    .inst2_i       (inst2_i),
    .inst1_addr_i  (inst1_addr_i),
    .inst2_addr_i  (inst2_addr_i),
    .pop_num_i     (pop_num_i),
    .head1_o       (head1_o),
    .head1_addr_o  (head1_addr_o),
    .head1_valid_o (head1_valid_o),
    .head2_o       (head2_o),
    .head2_addr_o  (head2_addr_o),
    .head2_valid_o (head2_valid_o),
    .full_o        (full_o),
    .count_o       (count_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    flush = 1'b0; inst1_valid_i = 1'b0; inst2_valid_i = 1'b0;
    inst1_i = '0; inst2_i = '0; inst1_addr_i = '0; inst2_addr_i = '0;
    pop_num_i = 2'd0;
  endtask

  // One clock of traffic: drive at negedge, compare against the model, then advance the model
  task automatic step(input logic fl, input logic v1, input logic v2,
                      input logic [31:0] i1, input logic [31:0] a1,
                      input logic [31:0] i2, input logic [31:0] a2,
                      input logic [1:0] pop);
    ifq_entry_t vis[$];
    ifq_entry_t incoming[$];
    ifq_entry_t e;
    int sz, preq, pe;
    bit mfull;
    flush = fl; inst1_valid_i = v1; inst2_valid_i = v2;
    inst1_i = i1; inst1_addr_i = a1; inst2_i = i2; inst2_addr_i = a2;
    pop_num_i = pop;
    #1;
    sz    = mq.size();
    mfull = sz > DEPTH - 2;
    if (v1 && !mfull) begin
      e.inst = i1; e.addr = a1; incoming.push_back(e);
      if (v2) begin e.inst = i2; e.addr = a2; incoming.push_back(e); end
    end
    vis = mq;
`ifdef IFQ_BYPASS_EN
    if (sz == 0 && !fl) vis = incoming;
`endif
    check("count", 64'(count_o), 64'(sz));
    check("full", 64'(full_o), 64'(mfull));
    check("h1_valid", 64'(head1_valid_o), 64'(vis.size() >= 1));
    check("h2_valid", 64'(head2_valid_o), 64'(vis.size() >= 2));
    if (vis.size() >= 1) check("h1_data", {head1_o, head1_addr_o}, 64'(vis[0]));
    if (vis.size() >= 2) check("h2_data", {head2_o, head2_addr_o}, 64'(vis[1]));
    preq = (pop == 2'd0) ? 0 : (pop == 2'd1) ? 1 : 2;
    if (fl) begin
      mq.delete();
    end else begin
      pe = (preq < vis.size()) ? preq : vis.size();
      if (pe >= 1) dut_pops.push_back(head1_addr_o);
      if (pe >= 2) dut_pops.push_back(head2_addr_o);
`ifdef IFQ_BYPASS_EN
      if (sz == 0) begin
        foreach (incoming[k]) mq.push_back(incoming[k]);
        for (int k = 0; k < pe; k++) void'(mq.pop_front());
      end else
`endif
      begin
        for (int k = 0; k < pe; k++) void'(mq.pop_front());
        foreach (incoming[k]) mq.push_back(incoming[k]);
      end
    end
    @(posedge clk);
    #1;
    drive_idle();
    @(negedge clk);
  endtask

  task automatic push2(input logic [31:0] a);
    step(1'b0, 1'b1, 1'b1, $urandom, a, $urandom, a + 32'd4, 2'd0);
  endtask

  task automatic push1(input logic [31:0] a);
    step(1'b0, 1'b1, 1'b0, $urandom, a, $urandom, 32'hdead_beef, 2'd0);
  endtask

  task automatic idle_pop(input logic [1:0] p);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, p);
  endtask

  task automatic do_flush();
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 2'd0);
  endtask

  initial begin
    int next_pc;
    int budget;
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_h1v", 64'(head1_valid_o), 64'd0);
    check("rst_h2v", 64'(head2_valid_o), 64'd0);
    check("rst_full", 64'(full_o), 64'd0);
    rst = 1'b0;

    // 1: first pair appears one cycle after the push edge
    step(1'b0, 1'b1, 1'b1, 32'h11, 32'hbfc0_0000, 32'h22, 32'hbfc0_0004, 2'd0);
    check("t1_count", 64'(count_o), 64'd2);
    check("t1_h1", 64'(head1_o), 64'h11);
    check("t1_h2", 64'(head2_o), 64'h22);
    check("t1_h2a", 64'(head2_addr_o), 64'hbfc0_0004);

    // 2: fill to 15, overflow push dropped, pop releases full
    do_flush();
    for (int i = 0; i < 7; i++) push2(32'h1000 + 32'(i * 8));
    push1(32'h1038);
    check("t2_count15", 64'(count_o), 64'd15);
    check("t2_full", 64'(full_o), 64'd1);
    push2(32'h2000);
    check("t2_dropped", 64'(count_o), 64'd15);
    idle_pop(2'd1);
    check("t2_count14", 64'(count_o), 64'd14);
    check("t2_notfull", 64'(full_o), 64'd0);

    // 3: over-pop clamps without pointer skew
    do_flush();
    push1(32'h3000);
    idle_pop(2'd2);
    check("t3_count", 64'(count_o), 64'd0);
    check("t3_h1v", 64'(head1_valid_o), 64'd0);
    push2(32'h3100);
    check("t3_noskew", 64'(head1_addr_o), 64'h3100);

    // 4: simultaneous push 2 / pop 2 at count 5
    do_flush();
    push2(32'h4000); push2(32'h4008); push1(32'h4010);
    step(1'b0, 1'b1, 1'b1, $urandom, 32'h4100, $urandom, 32'h4104, 2'd2);
    check("t4_count", 64'(count_o), 64'd5);
    check("t4_head", 64'(head1_addr_o), 64'h4008);

    // 5: 40 sequential PCs through wrap-around with random pops
    do_flush();
    dut_pops.delete();
    next_pc = 0;
    budget = 0;
    while ((next_pc < 40 || mq.size() != 0) && budget < 2000) begin
      logic v1, v2;
      v1 = (next_pc < 40) && (mq.size() <= DEPTH - 2) && ($urandom_range(0, 3) != 0);
      v2 = v1 && (next_pc + 1 < 40) && ($urandom_range(0, 1) == 1);
      step(1'b0, v1, v2, $urandom, 32'h8000_0000 + 32'(next_pc * 4),
           $urandom, 32'h8000_0000 + 32'(next_pc * 4 + 4), 2'($urandom_range(0, 3)));
      if (v1) next_pc += v2 ? 2 : 1;
      budget++;
    end
    check("t5_budget", 64'(budget < 2000), 64'd1);
    check("t5_npops", 64'(dut_pops.size()), 64'd40);
    for (int i = 0; i < 40 && i < dut_pops.size(); i++)
      check("t5_order", 64'(dut_pops[i]), 64'(32'h8000_0000 + 32'(i * 4)));

    // 6: flush wins over a same-cycle push
    do_flush();
    push2(32'h6000); push2(32'h6008); push2(32'h6010);
    check("t6_count6", 64'(count_o), 64'd6);
    step(1'b1, 1'b1, 1'b1, $urandom, 32'h6100, $urandom, 32'h6104, 2'd1);
    check("t6_count0", 64'(count_o), 64'd0);
    check("t6_h1v", 64'(head1_valid_o), 64'd0);
    check("t6_h2v", 64'(head2_valid_o), 64'd0);

`ifdef IFQ_BYPASS_EN
    // Bypass: push+pop 2 on an empty queue leaves it empty
    step(1'b0, 1'b1, 1'b1, $urandom, 32'h7000, $urandom, 32'h7004, 2'd2);
    check("byp_count", 64'(count_o), 64'd0);
`endif

    // Random traffic, including pushes while full and occasional flushes
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
           $urandom, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
